// File: rtl/id_ex_pipeline_reg_pkg.sv
// Shared widths, ALU op codes and bundle types for the ID/EX pipeline register.
package pipeline_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int ALU_CTRL_W = 3;

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALU_CTRL_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 3'b011;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT = 3'b101;
  localparam logic [ALU_CTRL_W-1:0] ALU_ILL = 3'b111;

  typedef struct packed {
    logic                  reg_write;
    logic                  result_src;
    logic                  mem_write;
    logic                  jump;
    logic                  branch;
    logic [ALU_CTRL_W-1:0] alu_control;
    logic                  alu_src;
  } ctrl_bundle_t;

  typedef struct packed {
    logic [XLEN-1:0]       rd1;
    logic [XLEN-1:0]       rd2;
    logic [XLEN-1:0]       pc;
    logic [XLEN-1:0]       pc_plus4;
    logic [XLEN-1:0]       imm_ext;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
  } dp_bundle_t;

  // A bubble is an all-zero bundle: no side effects, ALU op = add.
  localparam ctrl_bundle_t CTRL_BUBBLE = '{
    reg_write: 1'b0, result_src: 1'b0, mem_write: 1'b0, jump: 1'b0,
    branch: 1'b0, alu_control: ALU_ADD, alu_src: 1'b0
  };

endpackage

// File: rtl/id_ex_pipeline_reg_pipe_field_reg.sv
// Generic bundle register: async reset, synchronous clear (bubble) beats enable (hold).
module pipe_field_reg #(
  parameter int WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/id_ex_pipeline_reg.sv
// Decode->Execute pipeline register with stall (hold) and flush (bubble).
// Optional bubble counter output bubble_cnt_E when ID_EX_PERF_CNT_EN is defined.
module id_ex_pipeline_reg
  import pipeline_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall_E,
  input  logic                  flush_E,
  input  logic                  valid_D,
  input  logic                  RegWrite_D,
  input  logic                  ResultSrc_D,
  input  logic                  MemWrite_D,
  input  logic                  Jump_D,
  input  logic                  Branch_D,
  input  logic [ALU_CTRL_W-1:0] ALUControl_D,
  input  logic                  ALUSrc_D,
  input  logic [XLEN-1:0]       RD1_D,
  input  logic [XLEN-1:0]       RD2_D,
  input  logic [XLEN-1:0]       PC_D,
  input  logic [XLEN-1:0]       PCPlus4_D,
  input  logic [XLEN-1:0]       ImmExt_D,
  input  logic [REG_ADDR_W-1:0] Rs1_D,
  input  logic [REG_ADDR_W-1:0] Rs2_D,
  input  logic [REG_ADDR_W-1:0] Rd_D,
  output logic                  valid_E,
  output logic                  RegWrite_E,
  output logic                  ResultSrc_E,
  output logic                  MemWrite_E,
  output logic                  Jump_E,
  output logic                  Branch_E,
  output logic [ALU_CTRL_W-1:0] ALUControl_E,
  output logic                  ALUSrc_E,
  output logic [XLEN-1:0]       RD1_E,
  output logic [XLEN-1:0]       RD2_E,
  output logic [XLEN-1:0]       PC_E,
  output logic [XLEN-1:0]       PCPlus4_E,
  output logic [XLEN-1:0]       ImmExt_E,
  output logic [REG_ADDR_W-1:0] Rs1_E,
  output logic [REG_ADDR_W-1:0] Rs2_E,
  output logic [REG_ADDR_W-1:0] Rd_E
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0]           bubble_cnt_E
`endif
);

  localparam int CTRL_W = $bits(ctrl_bundle_t) + 1;
  localparam int DP_W   = $bits(dp_bundle_t);

  ctrl_bundle_t      w_ctrl_d;
  ctrl_bundle_t      w_ctrl_q;
  dp_bundle_t        w_dp_d;
  dp_bundle_t        w_dp_q;
  logic              w_valid_q;
  logic              w_en;
  logic [CTRL_W-1:0] w_ctrl_vec_d;
  logic [CTRL_W-1:0] w_ctrl_vec_q;
  logic [DP_W-1:0]   w_dp_vec_q;

  // An invalid decode slot must not carry side effects into EX.
  always_comb begin
    w_ctrl_d             = CTRL_BUBBLE;
    w_ctrl_d.result_src  = ResultSrc_D;
    w_ctrl_d.alu_control = ALUControl_D;
    w_ctrl_d.alu_src     = ALUSrc_D;
    if (valid_D) begin
      w_ctrl_d.reg_write = RegWrite_D;
      w_ctrl_d.mem_write = MemWrite_D;
      w_ctrl_d.jump      = Jump_D;
      w_ctrl_d.branch    = Branch_D;
    end
  end

  assign w_dp_d = '{
    rd1: RD1_D, rd2: RD2_D, pc: PC_D, pc_plus4: PCPlus4_D,
    imm_ext: ImmExt_D, rs1: Rs1_D, rs2: Rs2_D, rd: Rd_D
  };

  assign w_en         = ~stall_E;
  assign w_ctrl_vec_d = {valid_D, w_ctrl_d};

  pipe_field_reg #(.WIDTH(CTRL_W)) u_ctrl_reg (
    .i_clk   (clk),
    .i_reset (reset),
    .i_en    (w_en),
    .i_clr   (flush_E),
    .i_d     (w_ctrl_vec_d),
    .o_q     (w_ctrl_vec_q)
  );

  pipe_field_reg #(.WIDTH(DP_W)) u_dp_reg (
    .i_clk   (clk),
    .i_reset (reset),
    .i_en    (w_en),
    .i_clr   (flush_E),
    .i_d     (w_dp_d),
    .o_q     (w_dp_vec_q)
  );

  assign {w_valid_q, w_ctrl_q} = w_ctrl_vec_q;
  assign w_dp_q                = w_dp_vec_q;

  assign valid_E      = w_valid_q;
  assign RegWrite_E   = w_ctrl_q.reg_write;
  assign ResultSrc_E  = w_ctrl_q.result_src;
  assign MemWrite_E   = w_ctrl_q.mem_write;
  assign Jump_E       = w_ctrl_q.jump;
  assign Branch_E     = w_ctrl_q.branch;
  assign ALUControl_E = w_ctrl_q.alu_control;
  assign ALUSrc_E     = w_ctrl_q.alu_src;
  assign RD1_E        = w_dp_q.rd1;
  assign RD2_E        = w_dp_q.rd2;
  assign PC_E         = w_dp_q.pc;
  assign PCPlus4_E    = w_dp_q.pc_plus4;
  assign ImmExt_E     = w_dp_q.imm_ext;
  assign Rs1_E        = w_dp_q.rs1;
  assign Rs2_E        = w_dp_q.rs2;
  assign Rd_E         = w_dp_q.rd;

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] r_bubble_cnt;

  // Counts flush bubbles and unstalled loads of an empty decode slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bubble_cnt <= '0;
    end else if (flush_E || (!stall_E && !valid_D)) begin
      r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end
  end

  assign bubble_cnt_E = r_bubble_cnt;
`endif

  a_bubble_quiet: assert property (@(posedge clk)
    !valid_E |-> !(RegWrite_E | MemWrite_E | Jump_E | Branch_E));

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Randomised self-checking bench for id_ex_pipeline_reg against a behavioural model.
module tb_id_ex_pipeline_reg;
  import pipeline_pkg::*;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  stall_E, flush_E, valid_D;
  logic                  RegWrite_D, ResultSrc_D, MemWrite_D, Jump_D, Branch_D, ALUSrc_D;
  logic [ALU_CTRL_W-1:0] ALUControl_D;
  logic [XLEN-1:0]       RD1_D, RD2_D, PC_D, PCPlus4_D, ImmExt_D;
  logic [REG_ADDR_W-1:0] Rs1_D, Rs2_D, Rd_D;
  logic                  valid_E, RegWrite_E, ResultSrc_E, MemWrite_E, Jump_E, Branch_E, ALUSrc_E;
  logic [ALU_CTRL_W-1:0] ALUControl_E;
  logic [XLEN-1:0]       RD1_E, RD2_E, PC_E, PCPlus4_E, ImmExt_E;
  logic [REG_ADDR_W-1:0] Rs1_E, Rs2_E, Rd_E;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0]           bubble_cnt_E;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  id_ex_pipeline_reg dut (
    .clk(clk), .reset(reset), .stall_E(stall_E), .flush_E(flush_E), .valid_D(valid_D),
    .RegWrite_D(RegWrite_D), .ResultSrc_D(ResultSrc_D), .MemWrite_D(MemWrite_D),
    .Jump_D(Jump_D), .Branch_D(Branch_D), .ALUControl_D(ALUControl_D), .ALUSrc_D(ALUSrc_D),
    .RD1_D(RD1_D), .RD2_D(RD2_D), .PC_D(PC_D), .PCPlus4_D(PCPlus4_D), .ImmExt_D(ImmExt_D),
    .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rd_D(Rd_D),
    .valid_E(valid_E), .RegWrite_E(RegWrite_E), .ResultSrc_E(ResultSrc_E),
    .MemWrite_E(MemWrite_E), .Jump_E(Jump_E), .Branch_E(Branch_E),
    .ALUControl_E(ALUControl_E), .ALUSrc_E(ALUSrc_E),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .PC_E(PC_E), .PCPlus4_E(PCPlus4_E), .ImmExt_E(ImmExt_E),
    .Rs1_E(Rs1_E), .Rs2_E(Rs2_E), .Rd_E(Rd_E)
`ifdef ID_EX_PERF_CNT_EN
    , .bubble_cnt_E(bubble_cnt_E)
`endif
  );

  typedef struct packed {
    logic        valid, rw, rsrc, mw, jmp, br;
    logic [2:0]  alu;
    logic        asrc;
    logic [31:0] rd1, rd2, pc, pc4, imm;
    logic [4:0]  rs1, rs2, rd;
  } exp_t;

  exp_t        m;
  logic [31:0] m_cnt;

  // What E should show after an unstalled, unflushed edge.
  function automatic exp_t from_d();
    exp_t e;
    e.valid = valid_D;
    e.rw    = valid_D && RegWrite_D;
    e.mw    = valid_D && MemWrite_D;
    e.jmp   = valid_D && Jump_D;
    e.br    = valid_D && Branch_D;
    e.rsrc  = ResultSrc_D;
    e.alu   = ALUControl_D;
    e.asrc  = ALUSrc_D;
    e.rd1   = RD1_D;  e.rd2 = RD2_D;  e.pc = PC_D;  e.pc4 = PCPlus4_D;  e.imm = ImmExt_D;
    e.rs1   = Rs1_D;  e.rs2 = Rs2_D;  e.rd = Rd_D;
    return e;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m     <= '0;
      m_cnt <= '0;
    end else begin
      if (flush_E)       m <= '0;
      else if (!stall_E) m <= from_d();
      if (flush_E || (!stall_E && !valid_D)) m_cnt <= m_cnt + 32'd1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("valid_E", valid_E, m.valid);
    check("RegWrite_E", RegWrite_E, m.rw);
    check("ResultSrc_E", ResultSrc_E, m.rsrc);
    check("MemWrite_E", MemWrite_E, m.mw);
    check("Jump_E", Jump_E, m.jmp);
    check("Branch_E", Branch_E, m.br);
    check("ALUControl_E", ALUControl_E, m.alu);
    check("ALUSrc_E", ALUSrc_E, m.asrc);
    check("RD1_E", RD1_E, m.rd1);
    check("RD2_E", RD2_E, m.rd2);
    check("PC_E", PC_E, m.pc);
    check("PCPlus4_E", PCPlus4_E, m.pc4);
    check("ImmExt_E", ImmExt_E, m.imm);
    check("Rs1_E", Rs1_E, m.rs1);
    check("Rs2_E", Rs2_E, m.rs2);
    check("Rd_E", Rd_E, m.rd);
`ifdef ID_EX_PERF_CNT_EN
    check("bubble_cnt_E", bubble_cnt_E, m_cnt);
`endif
  end

  task automatic rand_d();
    valid_D      = ($urandom_range(0, 3) != 0);
    RegWrite_D   = 1'($urandom);
    ResultSrc_D  = 1'($urandom);
    MemWrite_D   = 1'($urandom);
    Jump_D       = 1'($urandom);
    Branch_D     = 1'($urandom);
    ALUSrc_D     = 1'($urandom);
    ALUControl_D = 3'($urandom);
    RD1_D        = $urandom;
    RD2_D        = $urandom;
    PC_D         = $urandom;
    PCPlus4_D    = PC_D + 32'd4;
    ImmExt_D     = $urandom;
    Rs1_D        = 5'($urandom);
    Rs2_D        = 5'($urandom);
    Rd_D         = 5'($urandom);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset   = 1'b0;
    stall_E = 1'b0;
    flush_E = 1'b0;
    rand_d();
    #1 reset = 1'b1;
    #2;
    check("reset_valid", valid_E, 1'b0);
    check("reset_pc", PC_E, 32'h0);
    tick();
    tick();
    reset = 1'b0;

    // lw x5, 8(rs1)
    rand_d();
    valid_D = 1'b1; RegWrite_D = 1'b1; ResultSrc_D = 1'b1; MemWrite_D = 1'b0;
    Jump_D = 1'b0; Branch_D = 1'b0; ALUSrc_D = 1'b1; ALUControl_D = 3'b000;
    Rd_D = 5'd5; ImmExt_D = 32'd8;
    tick();
    check("lw_valid", valid_E, 1'b1);
    check("lw_regwrite", RegWrite_E, 1'b1);
    check("lw_resultsrc", ResultSrc_E, 1'b1);
    check("lw_alusrc", ALUSrc_E, 1'b1);
    check("lw_rd", Rd_E, 5'd5);
    check("lw_imm", ImmExt_E, 32'd8);

    // Asynchronous reset in the middle of a cycle.
    #2 reset = 1'b1;
    #1;
    check("midrst_regwrite", RegWrite_E, 1'b0);
    check("midrst_valid", valid_E, 1'b0);
    check("midrst_rd", Rd_E, 5'd0);
    check("midrst_imm", ImmExt_E, 32'd0);
    #2 reset = 1'b0;

    // Stall holds A while D keeps changing.
    rand_d();
    valid_D = 1'b1; RegWrite_D = 1'b1; PC_D = 32'h100; Rd_D = 5'd7;
    tick();
    stall_E = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_d();
      tick();
      check("stall_pc", PC_E, 32'h100);
      check("stall_rd", Rd_E, 5'd7);
      check("stall_valid", valid_E, 1'b1);
    end
    stall_E = 1'b0;
    rand_d();
    valid_D = 1'b1; PC_D = 32'h200;
    tick();
    check("release_pc", PC_E, 32'h200);
    check("release_valid", valid_E, 1'b1);
`ifdef ID_EX_PERF_CNT_EN
    check("cnt_after_stall", bubble_cnt_E, 32'd0);
`endif

    // Flush over a store.
    rand_d();
    valid_D = 1'b1; MemWrite_D = 1'b1; ALUControl_D = 3'b011; ImmExt_D = 32'h44;
    flush_E = 1'b1;
    tick();
    flush_E = 1'b0;
    check("flush_memwrite", MemWrite_E, 1'b0);
    check("flush_valid", valid_E, 1'b0);
    check("flush_alu", ALUControl_E, 3'b000);
    check("flush_imm", ImmExt_E, 32'h0);
`ifdef ID_EX_PERF_CNT_EN
    check("cnt_after_flush", bubble_cnt_E, 32'd1);
`endif

    // Flush and stall together on a branch: flush wins.
    rand_d();
    valid_D = 1'b1; Branch_D = 1'b1; ALUControl_D = 3'b001; PC_D = 32'h3c;
    flush_E = 1'b1; stall_E = 1'b1;
    tick();
    flush_E = 1'b0; stall_E = 1'b0;
    check("flushstall_branch", Branch_E, 1'b0);
    check("flushstall_valid", valid_E, 1'b0);
    check("flushstall_pc", PC_E, 32'h0);
`ifdef ID_EX_PERF_CNT_EN
    check("cnt_after_flushstall", bubble_cnt_E, 32'd2);
`endif

    // Invalid slot: side effects squashed, datapath still loads.
    rand_d();
    valid_D = 1'b0; RegWrite_D = 1'b1; Jump_D = 1'b1; MemWrite_D = 1'b1; Branch_D = 1'b1;
    PC_D = 32'h300; ALUControl_D = 3'b111;
    tick();
    check("inv_regwrite", RegWrite_E, 1'b0);
    check("inv_jump", Jump_E, 1'b0);
    check("inv_valid", valid_E, 1'b0);
    check("inv_pc", PC_E, 32'h300);
    check("inv_alu", ALUControl_E, 3'b111);
`ifdef ID_EX_PERF_CNT_EN
    check("cnt_after_invalid", bubble_cnt_E, 32'd3);
`endif

    // Illegal ALU op on a valid instruction passes through.
    rand_d();
    valid_D = 1'b1; ALUControl_D = 3'b111; RegWrite_D = 1'b1;
    tick();
    check("ill_alu", ALUControl_E, 3'b111);
    check("ill_regwrite", RegWrite_E, 1'b1);
    check("ill_valid", valid_E, 1'b1);

    // Random traffic with occasional stalls, flushes and one mid-cycle reset.
    for (int i = 0; i < 400; i++) begin
      rand_d();
      stall_E = ($urandom_range(0, 3) == 0);
      flush_E = ($urandom_range(0, 6) == 0);
      if (i == 200) begin
        #2 reset = 1'b1;
        #1 reset = 1'b0;
      end
      tick();
    end
    stall_E = 1'b0;
    flush_E = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
